// File: rtl/led_animator_if.sv
// Control and LED-drive signals between the animator and its host/timer.
interface led_animator_if;
   logic       enable;
   logic       tick;
   logic       start;
   logic       stop;
   logic [1:0] mode;
   logic [3:0] repeat_count;
   logic [9:0] leds;
   logic       busy;
   logic       done;
   logic       timer_enable;

   modport master (
      output enable, tick, start, stop, mode, repeat_count,
      input  leds, busy, done, timer_enable
   );

   modport slave (
      input  enable, tick, start, stop, mode, repeat_count,
      output leds, busy, done, timer_enable
   );
endinterface

// File: rtl/led_animator.sv
// Ten-LED pattern animator: chase, bounce, blink and fill, stepped by an
// external 100 ms tick, for a fixed number of passes or until stopped.
module led_animator (
   input  logic          clock,
   input  logic          reset,
   led_animator_if.slave bus
);
   localparam int unsigned LED_W  = 10;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned MODE_W = 2;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [MODE_W-1:0] MODE_CHASE  = 2'b00;
   localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'b01;
   localparam logic [MODE_W-1:0] MODE_BLINK  = 2'b10;
   localparam logic [MODE_W-1:0] MODE_FILL   = 2'b11;

   localparam logic [LED_W-1:0] LED_NONE = '0;
   localparam logic [LED_W-1:0] LED_ALL  = '1;
   localparam logic [LED_W-1:0] LED_BOT  = LED_W'(1);
   localparam logic [LED_W-1:0] LED_TOP  = LED_BOT << (LED_W - 1);
   localparam logic [LED_W-1:0] LED_BOT1 = LED_BOT << 1;

   logic [0:0]        state,    state_nxt;
   logic [MODE_W-1:0] mode_q,   mode_nxt;
   logic [CNT_W-1:0]  rep_q,    rep_nxt;
   logic [CNT_W-1:0]  pass_cnt, pass_nxt;
   logic              dir_up,   dir_nxt;
   logic [LED_W-1:0]  leds_q,   leds_nxt;
   logic              busy_q,   busy_nxt;
   logic              done_q,   done_nxt;
   logic              te_q,     te_nxt;

   logic [LED_W-1:0]  step_leds;
   logic              step_dir;
   logic              wrap;
   logic [CNT_W-1:0]  pass_inc;

   function automatic logic [LED_W-1:0] init_pattern(input logic [MODE_W-1:0] m);
      return (m == MODE_BLINK) ? LED_ALL : LED_BOT;
   endfunction

   // State and output registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         mode_q   <= '0;
         rep_q    <= '0;
         pass_cnt <= '0;
         dir_up   <= 1'b1;
         leds_q   <= LED_NONE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         te_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_q   <= mode_nxt;
         rep_q    <= rep_nxt;
         pass_cnt <= pass_nxt;
         dir_up   <= dir_nxt;
         leds_q   <= leds_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         te_q     <= te_nxt;
      end
   end

   // Next-state, pattern stepping and output decode
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      rep_nxt   = rep_q;
      pass_nxt  = pass_cnt;
      dir_nxt   = dir_up;
      leds_nxt  = leds_q;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      step_leds = leds_q;
      step_dir  = dir_up;
      wrap      = 1'b0;
      pass_inc  = pass_cnt + CNT_W'(1);

      // wrap marks the step that lands back on the initial pattern
      case (mode_q)
         MODE_CHASE: begin
            step_leds = {leds_q[LED_W-2:0], leds_q[LED_W-1]};
            wrap      = (leds_q == LED_TOP);
         end
         MODE_BOUNCE: begin
            if (dir_up) begin
               if (leds_q == LED_TOP) begin
                  step_leds = leds_q >> 1;
                  step_dir  = 1'b0;
               end else begin
                  step_leds = leds_q << 1;
               end
            end else begin
               step_leds = leds_q >> 1;
               if (leds_q == LED_BOT1) begin
                  step_dir = 1'b1;
                  wrap     = 1'b1;
               end
            end
         end
         MODE_BLINK: begin
            step_leds = (leds_q == LED_NONE) ? LED_ALL : LED_NONE;
            wrap      = (leds_q == LED_NONE);
         end
         MODE_FILL: begin
            if (leds_q == LED_ALL) begin
               step_leds = LED_NONE;
            end else if (leds_q == LED_NONE) begin
               step_leds = LED_BOT;
               wrap      = 1'b1;
            end else begin
               step_leds = {leds_q[LED_W-2:0], 1'b1};
            end
         end
         default: ;
      endcase

      case (state)
         IDLE: begin
            if (bus.start && bus.enable) begin
               state_nxt = RUN;
               mode_nxt  = bus.mode;
               rep_nxt   = bus.repeat_count;
               leds_nxt  = init_pattern(bus.mode);
               dir_nxt   = 1'b1;
               pass_nxt  = '0;
               busy_nxt  = 1'b1;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_nxt = IDLE;
               leds_nxt  = LED_NONE;
               busy_nxt  = 1'b0;
            end else if (bus.enable && bus.tick) begin
               if (wrap && (rep_q != '0) && (pass_inc == rep_q)) begin
                  state_nxt = IDLE;
                  leds_nxt  = LED_NONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  leds_nxt = step_leds;
                  dir_nxt  = step_dir;
                  if (wrap) begin
                     pass_nxt = pass_inc;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            leds_nxt  = LED_NONE;
            busy_nxt  = 1'b0;
         end
      endcase

      te_nxt = busy_nxt && bus.enable;
   end

   assign bus.leds         = leds_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.timer_enable = te_q;
endmodule

// File: tb/tb_led_animator.sv
// Directed self-checking bench for led_animator.
module tb_led_animator;
   logic clock = 1'b0;
   logic reset;

   always #10 clock = ~clock;

   led_animator_if bus ();

   led_animator dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [9:0] exp_leds;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_tick();
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
   endtask

   task automatic start_run(input logic [1:0] m, input logic [3:0] r);
      bus.mode         = m;
      bus.repeat_count = r;
      bus.start        = 1'b1;
      cyc();
      bus.start        = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_leds"}, 16'(bus.leds), 16'h000);
      check({tag, "_busy"}, 16'(bus.busy), 16'h0);
      check({tag, "_te"},   16'(bus.timer_enable), 16'h0);
   endtask

   initial begin
      bus.enable = 1'b1;
      bus.tick = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.mode = 2'b00;
      bus.repeat_count = 4'd0;
      reset = 1'b0;
      cyc();
      cyc();
      check_idle("reset");
      check("reset_done", 16'(bus.done), 16'h0);
      reset = 1'b1;
      cyc();

      // chase, one pass
      start_run(2'b00, 4'd1);
      check("chase_start_leds", 16'(bus.leds), 16'h001);
      check("chase_start_busy", 16'(bus.busy), 16'h1);
      check("chase_start_te", 16'(bus.timer_enable), 16'h1);
      for (int i = 1; i <= 9; i++) begin
         pulse_tick();
         exp_leds = 10'h001 << i;
         check($sformatf("chase_t%0d", i), 16'(bus.leds), 16'(exp_leds));
         check($sformatf("chase_t%0d_done", i), 16'(bus.done), 16'h0);
         cyc();
      end
      pulse_tick();
      check("chase_end_done", 16'(bus.done), 16'h1);
      check_idle("chase_end");

      // start straight after done; blink, free-running, then stop with tick
      start_run(2'b10, 4'd0);
      check("blink_start_done", 16'(bus.done), 16'h0);
      check("blink_start_leds", 16'(bus.leds), 16'h3FF);
      check("blink_start_busy", 16'(bus.busy), 16'h1);
      for (int i = 1; i <= 7; i++) begin
         pulse_tick();
         check($sformatf("blink_t%0d", i), 16'(bus.leds), (i % 2 == 1) ? 16'h000 : 16'h3FF);
         check($sformatf("blink_t%0d_done", i), 16'(bus.done), 16'h0);
         cyc();
      end
      bus.stop = 1'b1;
      bus.tick = 1'b1;
      cyc();
      bus.stop = 1'b0;
      bus.tick = 1'b0;
      check_idle("blink_stop");
      check("blink_stop_done", 16'(bus.done), 16'h0);
      cyc();
      check("blink_stop_done2", 16'(bus.done), 16'h0);

      // bounce, two passes
      start_run(2'b01, 4'd2);
      for (int i = 1; i <= 36; i++) begin
         pulse_tick();
         if (i == 9)  check("bounce_t9", 16'(bus.leds), 16'h200);
         if (i == 10) check("bounce_t10", 16'(bus.leds), 16'h100);
         if (i == 18) begin
            check("bounce_t18", 16'(bus.leds), 16'h001);
            check("bounce_t18_busy", 16'(bus.busy), 16'h1);
         end
         if (i == 19) check("bounce_t19", 16'(bus.leds), 16'h002);
         if (i == 35) check("bounce_t35", 16'(bus.leds), 16'h002);
         if (i < 36) begin
            check($sformatf("bounce_t%0d_done", i), 16'(bus.done), 16'h0);
         end else begin
            check("bounce_end_done", 16'(bus.done), 16'h1);
            check_idle("bounce_end");
         end
         cyc();
      end
      check("bounce_after_done", 16'(bus.done), 16'h0);

      // start ignored while disabled
      bus.enable = 1'b0;
      start_run(2'b00, 4'd1);
      check("dis_start_busy", 16'(bus.busy), 16'h0);
      check("dis_start_leds", 16'(bus.leds), 16'h000);
      bus.enable = 1'b1;
      cyc();

      // fill with a pause after four ticks
      start_run(2'b11, 4'd1);
      check("fill_start_leds", 16'(bus.leds), 16'h001);
      for (int i = 1; i <= 4; i++) begin
         pulse_tick();
         cyc();
      end
      check("fill_t4", 16'(bus.leds), 16'h01F);
      bus.enable = 1'b0;
      cyc();
      check("fill_pause_te", 16'(bus.timer_enable), 16'h0);
      for (int i = 1; i <= 3; i++) begin
         pulse_tick();
         cyc();
      end
      check("fill_pause_leds", 16'(bus.leds), 16'h01F);
      check("fill_pause_busy", 16'(bus.busy), 16'h1);
      check("fill_pause_te2", 16'(bus.timer_enable), 16'h0);
      bus.enable = 1'b1;
      cyc();
      check("fill_resume_te", 16'(bus.timer_enable), 16'h1);
      for (int i = 1; i <= 6; i++) begin
         pulse_tick();
         cyc();
      end
      check("fill_t10", 16'(bus.leds), 16'h000);
      check("fill_t10_busy", 16'(bus.busy), 16'h1);
      check("fill_t10_done", 16'(bus.done), 16'h0);
      pulse_tick();
      check("fill_end_done", 16'(bus.done), 16'h1);
      check_idle("fill_end");
      cyc();

      // stop honoured while disabled
      start_run(2'b00, 4'd0);
      pulse_tick();
      check("stopdis_t1", 16'(bus.leds), 16'h002);
      bus.enable = 1'b0;
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
      bus.enable = 1'b1;
      check_idle("stopdis");
      check("stopdis_done", 16'(bus.done), 16'h0);
      cyc();

      // start/mode changes ignored in RUN, then reset mid-run
      start_run(2'b00, 4'd0);
      pulse_tick();
      cyc();
      pulse_tick();
      cyc();
      check("ign_t2", 16'(bus.leds), 16'h004);
      bus.mode = 2'b10;
      bus.repeat_count = 4'd1;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("ign_start_leds", 16'(bus.leds), 16'h004);
      check("ign_start_busy", 16'(bus.busy), 16'h1);
      pulse_tick();
      check("ign_t3", 16'(bus.leds), 16'h008);
      check("ign_t3_busy", 16'(bus.busy), 16'h1);
      reset = 1'b0;
      bus.tick = 1'b1;
      bus.start = 1'b1;
      cyc();
      reset = 1'b1;
      bus.tick = 1'b0;
      bus.start = 1'b0;
      check_idle("rst_run");
      check("rst_run_done", 16'(bus.done), 16'h0);
      cyc();
      check("rst_after_done", 16'(bus.done), 16'h0);
      check("rst_after_busy", 16'(bus.busy), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/led_animator.md
LED_ANIMATOR -- requirements
Module: led_animator

Interface
REQ-001 The block SHALL have `clock`, input, 1 bit: system clock, 50 MHz, all logic on rising edge.
REQ-002 The block SHALL have `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have `enable`, input, 1 bit: 0 = pause, with pattern, counters and state held.
REQ-004 The block SHALL have `tick`, input, 1 bit: one-clock pulse every 100 ms from the upstream 100 ms timer.
REQ-005 The block SHALL have `start`, input, 1 bit: level sampled each clock; acted on only in IDLE.
REQ-006 The block SHALL have `stop`, input, 1 bit: abort request; acted on only in RUN.
REQ-007 The block SHALL have `mode`, input, 2 bits: 00 chase, 01 bounce, 10 blink, 11 fill.
REQ-008 The block SHALL have `repeat_count`, input, 4 bits: number of pattern passes; 0 = run until stop.
REQ-009 The block SHALL have `leds`, output, 10 bits: LED drive, registered.
REQ-010 The block SHALL have `busy`, output, 1 bit: high while in RUN, registered.
REQ-011 The block SHALL have `done`, output, 1 bit: one-clock pulse on normal completion, registered.
REQ-012 The block SHALL have `timer_enable`, output, 1 bit: drives the upstream timer enable; equals busy AND enable, registered.

Function
REQ-013 The block SHALL implement exactly two states, IDLE and RUN.
REQ-014 In IDLE with start=1 and enable=1, the next edge SHALL:
  - latch mode and repeat_count;
  - load the initial pattern;
  - clear the pass counter;
  - set busy=1 and timer_enable=1;
  - enter RUN.
REQ-015 Initial patterns SHALL be:
  - chase 10'h001;
  - bounce 10'h001, direction up;
  - blink 10'h3FF;
  - fill 10'h001.
REQ-016 In RUN, pattern state SHALL advance exactly one step per tick=1 with enable=1; there SHALL be no change otherwise.
REQ-017 Chase SHALL rotate the single lit bit left, with 10'h200 followed by 10'h001; each pass is 10 ticks.
REQ-018 Bounce SHALL move the single lit bit upward to bit 9, then downward to bit 0, reversing at the ends without repeating the end bit; each pass is 18 ticks.
REQ-019 Blink SHALL alternate 10'h3FF and 10'h000; each pass is 2 ticks.
REQ-020 Fill SHALL step through the sequence 10'h001, 10'h003, ..., 10'h3FF, 10'h000, then back to 10'h001; each pass is 11 ticks.
REQ-021 A pass SHALL complete on the tick at which the pattern would return to its initial pattern (and, for bounce, the up direction); the pass counter (4 bits) SHALL increment on that tick.
REQ-022 If the latched repeat_count is nonzero and the incremented pass count equals it, that tick SHALL instead:
  - enter IDLE;
  - set leds=0, busy=0, timer_enable=0;
  - set done=1 for exactly one clock.
REQ-023 With latched repeat_count=0, the pass counter SHALL wrap freely and the run SHALL continue until stop.
REQ-024 stop=1 in RUN SHALL, on the next edge:
  - enter IDLE;
  - set leds=0, busy=0, timer_enable=0;
  - leave done at 0.
REQ-025 If stop and tick are high in the same cycle, stop SHALL take priority.
REQ-026 start during RUN SHALL be ignored; mode and repeat_count changes during RUN SHALL have no effect.
REQ-027 enable=0 SHALL deassert timer_enable on the next edge and freeze leds, the pass counter and state.
REQ-028 stop SHALL still be honoured while enable=0.
REQ-029 start while enable=0 SHALL be ignored.
REQ-030 done SHALL be 0 in every cycle other than the completion pulse.
REQ-031 After done, a start on the following cycle SHALL be accepted.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, leds=10'h000, busy=0, done=0, timer_enable=0, pass counter=0, direction=up, and latched mode/repeat=0, regardless of state.
REQ-033 Reset SHALL override start, stop, tick and enable.
REQ-034 Reset asserted mid-RUN SHALL abort without a done pulse.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  - Chase, repeat=1: start, then 10 ticks. leds SHALL go 001, 002, ..., 200; the 10th tick SHALL give leds=000, done=1 for one cycle, busy=0.
  - Bounce, repeat=2: start, then 36 ticks. After tick 9 leds SHALL be 200, after tick 10 leds SHALL be 100, and after tick 18 leds SHALL be 001 with busy=1; done SHALL pulse on tick 36.
  - Blink, repeat=0: start, then 7 ticks, then stop asserted together with a tick. After 7 ticks leds SHALL be 000; after stop leds SHALL be 000, busy=0, done SHALL never be asserted, and the same-cycle tick SHALL be ignored.
  - Fill, repeat=1, enable dropped after 4 ticks with ticks still arriving. leds SHALL hold 10'h01F and timer_enable=0; after re-enable, 7 more ticks SHALL give done.
  - Reset and ignored inputs: reset=0 mid-RUN (chase, leds=008) SHALL clear all outputs on the next edge. start pulsed during RUN and a mode change during RUN SHALL produce no effect.
